// File: rtl/note_voice_scheduler_if.sv
// note_voice_scheduler_if: note request handshake between voice requesters and the scheduler.
interface note_voice_scheduler_if #(
  parameter int NUM_VOICES = 4
);
  logic [NUM_VOICES-1:0]   NOTE_VALID;
  logic [5*NUM_VOICES-1:0] NOTE_IDX;
  logic [NUM_VOICES-1:0]   NOTE_GATE;
  logic [NUM_VOICES-1:0]   NOTE_READY;
  modport master (output NOTE_VALID, NOTE_IDX, NOTE_GATE, input NOTE_READY);
  modport slave (input NOTE_VALID, NOTE_IDX, NOTE_GATE, output NOTE_READY);
endinterface

// File: rtl/note_voice_scheduler.sv
// note_voice_scheduler: round-robin note ROM arbiter driving per-voice square-wave tone counters.
// Define NOTE_SCHED_MIX_EN to build the registered MIX popcount; otherwise MIX is tied to 0.
module note_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int DIV_W = 8,
  localparam int MIX_W = $clog2(NUM_VOICES + 1),
  localparam int PTR_W = $clog2(NUM_VOICES)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TICK,
  note_voice_scheduler_if.slave req,
  output logic [4:0]            ROM_ADDR,
  input  logic [DIV_W-1:0]      ROM_DATA,
  output logic [NUM_VOICES-1:0] VOICE_OUT,
  output logic [MIX_W-1:0]      MIX,
  output logic                  BUSY
);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_q, rr_d, grant_q, grant_d, win;
  logic                  gate_q, gate_d, found;
  logic [4:0]            addr_q, addr_d;
  logic [DIV_W-1:0]      div_q [NUM_VOICES];
  logic [DIV_W-1:0]      div_d [NUM_VOICES];
  logic [DIV_W-1:0]      cnt_q [NUM_VOICES];
  logic [DIV_W-1:0]      cnt_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] out_q, out_d, act_q, act_d;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!found && req.NOTE_VALID[(int'(rr_q) + i) % NUM_VOICES]) begin
        found = 1'b1;
        win = PTR_W'((int'(rr_q) + i) % NUM_VOICES);
      end
    end
  end
  assign req.NOTE_READY = (state_q == IDLE && found && !RESET) ? NUM_VOICES'(1) << win : '0;
  assign ROM_ADDR = addr_q;
  assign VOICE_OUT = out_q;
  assign BUSY = state_q == LOAD;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    gate_d = gate_q;
    addr_d = addr_q;
    div_d = div_q;
    cnt_d = cnt_q;
    out_d = out_q;
    act_d = act_q;
    if (state_q == IDLE && found) begin
      state_d = LOAD;
      grant_d = win;
      gate_d = req.NOTE_GATE[win];
      addr_d = req.NOTE_IDX[5*int'(win) +: 5];
      rr_d = (int'(win) == NUM_VOICES - 1) ? '0 : win + 1'b1;
    end else if (state_q == LOAD) begin
      state_d = IDLE;
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (TICK) begin
        if (!act_q[v]) begin
          out_d[v] = 1'b0;
        end else if (cnt_q[v] <= DIV_W'(1)) begin
          out_d[v] = ~out_q[v];
          cnt_d[v] = div_q[v];
        end else begin
          cnt_d[v] = cnt_q[v] - 1'b1;
        end
      end
      // A lookup landing on the same cycle as a tick overrides that voice's tick.
      if (state_q == LOAD && int'(grant_q) == v) begin
        div_d[v] = ROM_DATA;
        cnt_d[v] = ROM_DATA;
        out_d[v] = 1'b0;
        act_d[v] = gate_q & (ROM_DATA != '0);
      end
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      rr_q <= '0;
      grant_q <= '0;
      gate_q <= 1'b0;
      addr_q <= '0;
      div_q <= '{default: '0};
      cnt_q <= '{default: '0};
      out_q <= '0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      gate_q <= gate_d;
      addr_q <= addr_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      act_q <= act_d;
    end
  end
`ifdef NOTE_SCHED_MIX_EN
  logic [MIX_W-1:0] mix_q, mix_d;
  always_comb begin
    mix_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) mix_d = mix_d + MIX_W'(out_q[v]);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) mix_q <= '0;
    else mix_q <= mix_d;
  end
  assign MIX = mix_q;
`else
  assign MIX = '0;
`endif
endmodule

// File: tb/tb_note_voice_scheduler.sv
// tb_note_voice_scheduler: directed stimulus with a per-cycle behavioural model plus literal spot checks.
module tb_note_voice_scheduler;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int MW = $clog2(N + 1);
  logic CLK = 0, RESET = 0, TICK = 0;
  logic [4:0] ROM_ADDR;
  logic [DW-1:0] ROM_DATA;
  logic [N-1:0] VOICE_OUT;
  logic [MW-1:0] MIX;
  logic BUSY;
  logic [7:0] rom_tab [32];
  bit rom_zero = 0;
  int checks = 0, failures = 0;
`ifdef NOTE_SCHED_MIX_EN
  localparam bit MIX_ON = 1;
`else
  localparam bit MIX_ON = 0;
`endif
  note_voice_scheduler_if #(.NUM_VOICES(N)) nif ();
  note_voice_scheduler #(.NUM_VOICES(N), .DIV_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .req(nif.slave), .ROM_ADDR(ROM_ADDR),
    .ROM_DATA(ROM_DATA), .VOICE_OUT(VOICE_OUT), .MIX(MIX), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  assign ROM_DATA = rom_zero ? '0 : rom_tab[ROM_ADDR];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Model: arbiter position plus, per voice, the tick count since its last lookup.
  bit m_idle = 1;
  bit m_gate = 0;
  int m_rr = 0, m_grant = 0, m_addr = 0, m_mix = 0;
  bit m_act [N];
  int m_div [N];
  int m_k [N];
  always @(negedge CLK) begin
    logic [N-1:0] eo, er;
    int w, d;
    bit f;
    if (RESET) begin
      m_idle = 1; m_rr = 0; m_grant = 0; m_addr = 0; m_gate = 0; m_mix = 0;
      for (int v = 0; v < N; v++) begin m_act[v] = 0; m_div[v] = 0; m_k[v] = 0; end
    end
    eo = '0;
    for (int v = 0; v < N; v++) eo[v] = m_act[v] && ((m_k[v] / m_div[v]) % 2 == 1);
    er = '0; f = 0; w = 0;
    if (!RESET && m_idle)
      for (int i = 0; i < N; i++)
        if (!f && nif.NOTE_VALID[(m_rr + i) % N]) begin f = 1; w = (m_rr + i) % N; end
    if (f) er[w] = 1'b1;
    chk("ready", nif.NOTE_READY, er);
    chk("busy", BUSY, !m_idle);
    chk("rom_addr", ROM_ADDR, m_addr);
    chk("voice_out", VOICE_OUT, eo);
    chk("mix", MIX, MIX_ON ? m_mix : 0);
    if (!RESET) begin
      m_mix = $countones(eo);
      for (int v = 0; v < N; v++) if (TICK && m_act[v]) m_k[v]++;
      if (!m_idle) begin
        d = rom_zero ? 0 : rom_tab[m_addr];
        m_div[m_grant] = d; m_k[m_grant] = 0; m_act[m_grant] = m_gate && d != 0; m_idle = 1;
      end else if (f) begin
        m_grant = w; m_gate = nif.NOTE_GATE[w]; m_addr = nif.NOTE_IDX[5*w +: 5];
        m_rr = (w + 1) % N; m_idle = 0;
      end
    end
  end
  task automatic cyc(bit drop = 1);
    logic [N-1:0] rd;
    @(negedge CLK);
    rd = nif.NOTE_READY;
    @(posedge CLK);
    #1;
    if (drop) nif.NOTE_VALID = nif.NOTE_VALID & ~rd;
  endtask
  task automatic req(int v, int idx, bit gate);
    nif.NOTE_IDX[5*v +: 5] = 5'(idx);
    nif.NOTE_GATE[v] = gate;
    nif.NOTE_VALID[v] = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rom_tab[i] = 8'(40 + i);
    rom_tab[0] = 128; rom_tab[12] = 64; rom_tab[31] = 21;
    nif.NOTE_VALID = '0; nif.NOTE_GATE = '0; nif.NOTE_IDX = '0;
    #1 RESET = 1; TICK = 1;
    cyc();
    #1 chk("rst_vout", VOICE_OUT, 0); chk("rst_busy", BUSY, 0); chk("rst_addr", ROM_ADDR, 0);
    chk("rst_mix", MIX, 0);
    cyc(); RESET = 0; cyc();
    req(0, 0, 1);
    #1 chk("t1_ready", nif.NOTE_READY, 4'b0001);
    cyc();
    #1 chk("t1_busy", BUSY, 1); chk("t1_addr", ROM_ADDR, 0);
    cyc();
    repeat (127) cyc();
    #1 chk("t1_low", VOICE_OUT[0], 0);
    cyc();
    #1 chk("t1_high", VOICE_OUT[0], 1);
    repeat (128) cyc();
    #1 chk("t1_low2", VOICE_OUT[0], 0);
    RESET = 1; cyc(); RESET = 0;
    for (int v = 0; v < N; v++) req(v, v + 1, 1);
    for (int i = 0; i < N; i++) begin
      #1 chk("t2_ready", nif.NOTE_READY, 32'(1) << i);
      cyc();
      #1 chk("t2_busy", BUSY, 1);
      cyc();
    end
    repeat (60) cyc();
    req(2, 31, 1);
    repeat (23) cyc();
    #1 chk("t3_on", VOICE_OUT[2], 1);
    repeat (50) cyc();
    req(2, 31, 0);
    repeat (2) cyc();
    #1 chk("t3_off", VOICE_OUT[2], 0);
    repeat (100) cyc();
    #1 chk("t3_off100", VOICE_OUT[2], 0);
    TICK = 0; RESET = 1; cyc(); RESET = 0;
    req(0, 12, 1); req(1, 12, 1);
    repeat (4) cyc();
    TICK = 1;
    repeat (64) cyc();
    #1 chk("t4_vhigh", VOICE_OUT[1:0], 2'b11);
    cyc();
    #1 chk("t4_mix2", MIX, MIX_ON ? 2 : 0);
    repeat (63) cyc();
    #1 chk("t4_vlow", VOICE_OUT[1:0], 2'b00); chk("t4_mix_lag", MIX, MIX_ON ? 2 : 0);
    cyc();
    #1 chk("t4_mix0", MIX, 0);
    rom_zero = 1; req(3, 5, 1);
    repeat (2) cyc();
    rom_zero = 0;
    repeat (50) cyc();
    #1 chk("t5_zero", VOICE_OUT[3], 0);
    RESET = 1; cyc(); RESET = 0;
    req(0, 1, 1);
    repeat (47) cyc();
    #1 chk("t6_v0_on", VOICE_OUT[0], 1);
    req(1, 7, 1);
    #1 chk("t6_ready", nif.NOTE_READY, 4'b0010);
    cyc(0);
    #1 chk("t6_busy", BUSY, 1);
    RESET = 1; nif.NOTE_VALID = 4'b1010;
    #1 chk("t6_rst_busy", BUSY, 0); chk("t6_rst_vout", VOICE_OUT, 0);
    chk("t6_rst_ready", nif.NOTE_READY, 0); chk("t6_rst_addr", ROM_ADDR, 0);
    cyc(0); RESET = 0;
    #1 chk("t6_regrant", nif.NOTE_READY, 4'b0010);
    repeat (8) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
